// File: rtl/dff_bist.sv
// Self-test sequencer for one D flip-flop with synchronous active-low reset.
// It drives D and reset, checks Q one cycle later, and reports the verdict, the error count and the first failing check.
module dff_bist #(
  parameter int         N_VECTORS = 16,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         ERR_W     = 8,
  localparam int        IDX_W     = $clog2(N_VECTORS + 2)
) (
  input  logic             CLK,
  input  logic             n_res,
  input  logic             start,
  input  logic             dut_q,
  output logic             dut_d,
  output logic             dut_n_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_ASSERT,
    S_RST_CHK,
    S_DRIVE,
    S_CHK_LAST,
    S_HOLD1,
    S_HOLD2,
    S_DONE
  } state_e;

  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(N_VECTORS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VECTORS);
  localparam logic [IDX_W-1:0] IDX_HOLD = IDX_W'(N_VECTORS + 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic             exp_q, exp_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             dut_d_q, dut_d_d;
  logic             dut_nres_q, dut_nres_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             check_en;
  logic             check_exp;
  logic [IDX_W-1:0] check_idx;
  logic             mismatch;

  always_ff @(posedge CLK) begin
    if (!n_res) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      vec_q      <= '0;
      exp_q      <= 1'b0;
      err_q      <= '0;
      idx_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      dut_d_q    <= 1'b0;
      dut_nres_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      vec_q      <= vec_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      dut_d_q    <= dut_d_d;
      dut_nres_q <= dut_nres_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Sequencing and checks; exp_q always holds the D value driven one cycle earlier.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    vec_d     = vec_q;
    exp_d     = exp_q;
    err_d     = err_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    check_en  = 1'b0;
    check_exp = 1'b0;
    check_idx = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST_ASSERT;
          lfsr_d  = SEED_EFF;
          err_d   = '0;
          idx_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_RST_ASSERT: begin
        state_d = S_RST_CHK;
        vec_d   = '0;
      end
      S_RST_CHK: begin
        check_en = 1'b1;
        state_d  = S_DRIVE;
      end
      S_DRIVE: begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
        exp_d  = dut_d_q;
        if (vec_q != '0) begin
          check_en  = 1'b1;
          check_exp = exp_q;
          check_idx = vec_q;
        end
        if (vec_q == LAST_VEC) begin
          state_d = S_CHK_LAST;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      S_CHK_LAST: begin
        check_en  = 1'b1;
        check_exp = exp_q;
        check_idx = IDX_LAST;
        state_d   = S_HOLD1;
      end
      S_HOLD1: begin
        state_d = S_HOLD2;
      end
      S_HOLD2: begin
        check_en  = 1'b1;
        check_idx = IDX_HOLD;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mismatch = check_en && (dut_q != check_exp);
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        idx_d = check_idx;
      end
    end

    if (state_d == S_DONE) begin
      pass_d = (err_d == '0);
      fail_d = (err_d != '0);
    end
  end

  // Registered outputs are decoded from the state being entered so they line up with it.
  always_comb begin
    dut_d_d    = 1'b0;
    dut_nres_d = 1'b1;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    case (state_d)
      S_RST_ASSERT, S_HOLD1, S_HOLD2: begin
        dut_d_d    = 1'b1;
        dut_nres_d = 1'b0;
      end
      S_DRIVE: begin
        dut_d_d = lfsr_d[0];
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      S_IDLE: begin
        busy_d = 1'b0;
      end
      default: begin
        dut_d_d = 1'b0;
      end
    endcase
  end

  assign dut_d     = dut_d_q;
  assign dut_n_res = dut_nres_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_count = err_q;
  assign fail_idx  = idx_q;

endmodule

// File: tb/tb_dff_bist.sv
// Bench for dff_bist: a behavioural flop with selectable faults sits under test,
// and each run is compared with a reference built from the LFSR recurrence and the check list.
module tb_dff_bist;

  localparam int N     = 16;
  localparam int IDX_W = $clog2(N + 2);

  localparam logic [1:0] M_IDEAL  = 2'd0;
  localparam logic [1:0] M_STUCK0 = 2'd1;
  localparam logic [1:0] M_STUCK1 = 2'd2;
  localparam logic [1:0] M_PLAIN  = 2'd3;

  logic             CLK   = 1'b0;
  logic             n_res = 1'b0;
  logic             start = 1'b0;
  logic             dut_q;
  logic             dut_d;
  logic             dut_n_res;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [7:0]       err_count;
  logic [IDX_W-1:0] fail_idx;

  logic [1:0] mode    = M_IDEAL;
  logic       preload = 1'b0;
  logic       flop_q  = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] ref_bits;

  int           obs_done_cyc;
  int           obs_busy_cnt;
  logic         obs_timeout;
  logic         obs_pf_bad;
  logic         obs_done_after;
  logic [N-1:0] obs_dseq;
  logic [31:0]  obs_nres;
  logic         obs_pass;
  logic         obs_fail;
  logic [7:0]   obs_err;
  logic [IDX_W-1:0] obs_idx;

  dff_bist #(.N_VECTORS(N), .SEED(8'hA5), .ERR_W(8)) u_dut (
    .CLK       (CLK),
    .n_res     (n_res),
    .start     (start),
    .dut_q     (dut_q),
    .dut_d     (dut_d),
    .dut_n_res (dut_n_res),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .err_count (err_count),
    .fail_idx  (fail_idx)
  );

  always #5 CLK = ~CLK;

  // Flop under test: ideal sync-reset DFF, Q stuck at 0/1, or a DFF that ignores reset.
  always @(posedge CLK) begin
    if (preload) flop_q <= 1'b1;
    else if (mode == M_PLAIN) flop_q <= dut_d;
    else if (!dut_n_res) flop_q <= 1'b0;
    else flop_q <= dut_d;
  end

  assign dut_q = (mode == M_STUCK0) ? 1'b0 : (mode == M_STUCK1) ? 1'b1 : flop_q;

  function automatic logic [N-1:0] lfsr_stream(input logic [7:0] seed);
    logic [N+7:0] b;
    logic [7:0]   s;
    s = (seed == 8'h00) ? 8'h01 : seed;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = s[i];
    for (int i = 8; i < N + 8; i++) b[i] = b[i-8] ^ b[i-6] ^ b[i-5] ^ b[i-4];
    return b[N-1:0];
  endfunction

  // Expected error count and first failing index over checks 0..upto for a given flop behaviour.
  task automatic model_result(input logic [1:0] m, input int upto, output int err, output int idx);
    logic req;
    logic seen;
    err = 0;
    idx = 0;
    for (int i = 0; i <= upto; i++) begin
      req = (i >= 1 && i <= N) ? ref_bits[i-1] : 1'b0;
      case (m)
        M_STUCK0: seen = 1'b0;
        M_STUCK1: seen = 1'b1;
        M_PLAIN:  seen = (i >= 1 && i <= N) ? ref_bits[i-1] : 1'b1;
        default:  seen = req;
      endcase
      if (seen != req) begin
        if (err == 0) idx = i;
        err++;
      end
    end
  endtask

  task automatic run_once(input int mid_cyc);
    obs_done_cyc   = 0;
    obs_busy_cnt   = 0;
    obs_timeout    = 1'b0;
    obs_pf_bad     = 1'b0;
    obs_done_after = 1'b0;
    obs_dseq       = '0;
    obs_nres       = '1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 1; c <= 60 && obs_done_cyc == 0; c++) begin
      if (busy) obs_busy_cnt++;
      if ((busy && (pass || fail)) || (pass && fail)) obs_pf_bad = 1'b1;
      if (c >= 3 && c < 3 + N) obs_dseq[c-3] = dut_d;
      if (c < 32) obs_nres[c] = dut_n_res;
      if (done) begin
        obs_done_cyc = c;
        obs_pass     = pass;
        obs_fail     = fail;
        obs_err      = err_count;
        obs_idx      = fail_idx;
      end
      start = (c == mid_cyc);
      @(negedge CLK);
    end
    start = 1'b0;
    if (obs_done_cyc == 0) obs_timeout = 1'b1;
    else obs_done_after = done;
  endtask

  task automatic test_reset();
    n_res = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, done, pass, fail, dut_d, dut_n_res} !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000001", {busy, done, pass, fail, dut_d, dut_n_res});
    end
    checks++;
    if (err_count !== 8'd0 || fail_idx !== '0) begin
      failures++;
      $display("[TB] FAIL reset_counts: got err=%0d idx=%0d expected 0/0", err_count, fail_idx);
    end
    start = 1'b0;
    n_res = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_ideal();
    int e;
    int i;
    logic [31:0] exp_nres;
    mode = M_IDEAL;
    repeat ($urandom_range(0, 4)) @(negedge CLK);
    model_result(M_IDEAL, N + 1, e, i);
    exp_nres = '1;
    exp_nres[1] = 1'b0;
    exp_nres[N+4] = 1'b0;
    exp_nres[N+5] = 1'b0;
    run_once(0);
    checks++;
    if (obs_timeout !== 1'b0) begin failures++; $display("[TB] FAIL ideal_timeout: no done within 60 cycles"); end
    checks++;
    if (obs_done_cyc !== N + 6) begin failures++; $display("[TB] FAIL ideal_done_cycle: got %0d expected %0d", obs_done_cyc, N + 6); end
    checks++;
    if (obs_busy_cnt !== N + 5) begin failures++; $display("[TB] FAIL ideal_busy_cycles: got %0d expected %0d", obs_busy_cnt, N + 5); end
    checks++;
    if (obs_dseq !== ref_bits) begin failures++; $display("[TB] FAIL ideal_d_sequence: got %b expected %b", obs_dseq, ref_bits); end
    checks++;
    if (obs_nres[N+6:0] !== exp_nres[N+6:0]) begin
      failures++;
      $display("[TB] FAIL ideal_nres_pattern: got %b expected %b", obs_nres[N+6:0], exp_nres[N+6:0]);
    end
    checks++;
    if ({obs_pass, obs_fail} !== 2'b10 || int'(obs_err) !== e || int'(obs_idx) !== i) begin
      failures++;
      $display("[TB] FAIL ideal_verdict: got pass=%b fail=%b err=%0d idx=%0d expected 1/0/%0d/%0d", obs_pass, obs_fail, obs_err, obs_idx, e, i);
    end
    checks++;
    if (obs_done_after !== 1'b0 || obs_pf_bad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ideal_done_pulse: got done_after=%b pf_bad=%b expected 0/0", obs_done_after, obs_pf_bad);
    end
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("[TB] FAIL ideal_pass_held: got pass=%b fail=%b expected 1/0", pass, fail); end
  endtask

  task automatic test_fault(input logic [1:0] m, input string name);
    int e;
    int i;
    mode = m;
    if (m == M_PLAIN) begin
      preload = 1'b1;
      @(negedge CLK);
      preload = 1'b0;
    end
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    model_result(m, N + 1, e, i);
    run_once(0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_done_cyc !== N + 6) begin
      failures++;
      $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", name, obs_done_cyc, N + 6);
    end
    checks++;
    if ({obs_pass, obs_fail} !== {e == 0, e != 0}) begin
      failures++;
      $display("[TB] FAIL %s_verdict: got pass=%b fail=%b expected %b/%b", name, obs_pass, obs_fail, e == 0, e != 0);
    end
    checks++;
    if (int'(obs_err) !== e) begin failures++; $display("[TB] FAIL %s_err_count: got %0d expected %0d", name, obs_err, e); end
    checks++;
    if (int'(obs_idx) !== i) begin failures++; $display("[TB] FAIL %s_fail_idx: got %0d expected %0d", name, obs_idx, i); end
    mode = M_IDEAL;
  endtask

  task automatic test_abort();
    int e;
    int i;
    int done_seen;
    int busy_seen;
    mode = M_STUCK1;
    model_result(M_STUCK1, 4, e, i);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || int'(err_count) !== e) begin
      failures++;
      $display("[TB] FAIL abort_pre_state: got busy=%b err=%0d expected 1/%0d", busy, err_count, e);
    end
    n_res = 1'b0;
    @(negedge CLK);
    n_res = 1'b1;
    checks++;
    if ({busy, done, pass, fail, dut_d, dut_n_res} !== 6'b000001 || err_count !== 8'd0 || fail_idx !== '0) begin
      failures++;
      $display("[TB] FAIL abort_reset_values: got flags=%b err=%0d idx=%0d expected 000001/0/0",
               {busy, done, pass, fail, dut_d, dut_n_res}, err_count, fail_idx);
    end
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    checks++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got done=%0d busy=%0d expected 0/0", done_seen, busy_seen);
    end
    mode = M_IDEAL;
    run_once(0);
    checks++;
    if (obs_done_cyc !== N + 6 || {obs_pass, obs_fail} !== 2'b10 || obs_err !== 8'd0) begin
      failures++;
      $display("[TB] FAIL abort_rerun: got cyc=%0d pass=%b fail=%b err=%0d expected %0d/1/0/0",
               obs_done_cyc, obs_pass, obs_fail, obs_err, N + 6);
    end
  endtask

  task automatic test_mid_start();
    int mid;
    int done_seen;
    mode = M_IDEAL;
    mid = $urandom_range(2, N + 5);
    run_once(mid);
    checks++;
    if (obs_done_cyc !== N + 6 || obs_busy_cnt !== N + 5 || {obs_pass, obs_fail} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL mid_start_run: got cyc=%0d busy=%0d pass=%b (start at %0d) expected %0d/%0d/1",
               obs_done_cyc, obs_busy_cnt, obs_pass, mid, N + 6, N + 5);
    end
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) done_seen++;
      @(negedge CLK);
    end
    checks++;
    if (done_seen !== 0) begin failures++; $display("[TB] FAIL mid_start_ignored: got %0d active cycles expected 0", done_seen); end
  endtask

  task automatic test_back_to_back();
    int e;
    int i;
    int dcount;
    int dc[3];
    logic [7:0] err23;
    logic [7:0] err24;
    logic fail23;
    logic fail24;
    logic busy24;
    mode = M_STUCK0;
    model_result(M_STUCK0, N + 1, e, i);
    dcount = 0;
    dc = '{0, 0, 0};
    err23 = '0; err24 = '1; fail23 = 1'b0; fail24 = 1'b1; busy24 = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    for (int c = 1; c <= 3 * (N + 7); c++) begin
      if (done) begin
        if (dcount < 3) dc[dcount] = c;
        dcount++;
      end
      if (c == N + 7) begin err23 = err_count; fail23 = fail; end
      if (c == N + 8) begin err24 = err_count; fail24 = fail; busy24 = busy; end
      if (c == 3 * (N + 7)) start = 1'b0;
      @(negedge CLK);
    end
    start = 1'b0;
    checks++;
    if (dcount !== 3 || dc[0] !== N + 6) begin
      failures++;
      $display("[TB] FAIL b2b_done_count: got %0d pulses first at %0d expected 3 first at %0d", dcount, dc[0], N + 6);
    end
    checks++;
    if (dc[1] - dc[0] !== N + 7 || dc[2] - dc[1] !== N + 7) begin
      failures++;
      $display("[TB] FAIL b2b_spacing: got %0d,%0d expected %0d", dc[1] - dc[0], dc[2] - dc[1], N + 7);
    end
    checks++;
    if (int'(err23) !== e || fail23 !== (e != 0)) begin
      failures++;
      $display("[TB] FAIL b2b_held_result: got err=%0d fail=%b expected %0d/%b", err23, fail23, e, e != 0);
    end
    checks++;
    if (err24 !== 8'd0 || fail24 !== 1'b0 || busy24 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_clear_on_start: got err=%0d fail=%b busy=%b expected 0/0/1", err24, fail24, busy24);
    end
    mode = M_IDEAL;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    ref_bits = lfsr_stream(8'hA5);
    @(negedge CLK);
    test_reset();
    test_ideal();
    test_fault(M_STUCK0, "stuck0");
    test_fault(M_STUCK1, "stuck1");
    test_fault(M_PLAIN, "plain_dff");
    test_abort();
    test_mid_start();
    test_back_to_back();
    test_ideal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish by time 100000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
